// File: rtl/apb_pkg.sv
// Shared definitions for the APB arbiter: FSM state encoding and the default
// watchdog limit used when no TIMEOUT override is given.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/apb_arbiter.sv
// Two-requester APB master arbiter.
// Requester 0 (instruction fetch) and requester 1 (data) share a single APB
// master port. Grants are round-robin on ties. A watchdog forces an error
// completion when the slave never asserts pready.
//
// Ports:
//   pclk, presetn            clock (rising edge), async active-low reset
//   mX_req/addr/wdata/write/stb   requester X transfer request, held until done
//   mX_done/rdata/err        requester X one-cycle completion, read data, error
//   paddr/pdata/pwrite/pstb/psel/penable   APB master outputs to the decoder
//   prdata/pready/perr       decoder response
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  pclk,
    input  logic                  presetn,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_write,
    input  logic [3:0]            m0_stb,
    output logic                  m0_done,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_write,
    input  logic [3:0]            m1_stb,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    output logic                  psel,
    output logic                  penable,

    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    apb_state_t      state;
    logic [WD_W-1:0] wdog;
    logic            owner;       // requester currently holding the bus
    logic            last_grant;  // requester granted most recently
    logic            grant_m1;

    // m1 wins when it is the only requester, or on a tie when m0 went last.
    assign grant_m1 = m1_req && (!m0_req || !last_grant);

    // Decoded from state so reset drops them without waiting for a clock.
    assign psel    = (state == SETUP) || (state == ACCESS);
    assign penable = (state == ACCESS);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            wdog       <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            paddr      <= '0;
            pdata      <= '0;
            pwrite     <= 1'b0;
            pstb       <= '0;
            m0_done    <= 1'b0;
            m0_rdata   <= '0;
            m0_err     <= 1'b0;
            m1_done    <= 1'b0;
            m1_rdata   <= '0;
            m1_err     <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner  <= grant_m1;
                        paddr  <= grant_m1 ? m1_addr  : m0_addr;
                        pdata  <= grant_m1 ? m1_wdata : m0_wdata;
                        pwrite <= grant_m1 ? m1_write : m0_write;
                        if (grant_m1) begin
                            pstb <= m1_write ? m1_stb : 4'b0000;
                        end else begin
                            pstb <= m0_write ? m0_stb : 4'b0000;
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    wdog  <= '0;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (pready || (wdog == WD_LAST)) begin
                        // A timeout completes as an error with zeroed read data.
                        if (owner) begin
                            m1_rdata <= pready ? prdata : '0;
                            m1_err   <= pready ? perr : 1'b1;
                            m1_done  <= 1'b1;
                        end else begin
                            m0_rdata <= pready ? prdata : '0;
                            m0_err   <= pready ? perr : 1'b1;
                            m0_done  <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-003 SHALL have parameter TIMEOUT, default 256, meaning maximum ACCESS cycles before forced error completion.
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports listed below.
REQ-005 SHALL have port pclk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port presetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports m0_req / m1_req  input  1  transfer request from requester 0 (instruction fetch) / 1 (data), held until done.
REQ-008 SHALL have ports m0_addr / m1_addr  input  ADDR_WIDTH  transfer address.
REQ-009 SHALL have ports m0_wdata / m1_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports m0_write / m1_write  input  1  1 = write, 0 = read.
REQ-011 SHALL have ports m0_stb / m1_stb  input  4  write byte strobes.
REQ-012 SHALL have ports m0_done / m1_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports m0_rdata / m1_rdata  output  DATA_WIDTH  read data, valid with done.
REQ-014 SHALL have ports m0_err / m1_err  output  1  error flag, valid with done.
REQ-015 SHALL have ports paddr  output  ADDR_WIDTH; pdata  output  DATA_WIDTH; pwrite  output  1; pstb  output  4; psel  output  1; penable  output  1: APB master signals to the address decoder.
REQ-016 SHALL have ports prdata  input  DATA_WIDTH; pready  input  1; perr  input  1: decoder response.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-018 In IDLE, SHALL sample m0_req/m1_req; if any is set, grant one, register its addr/wdata/write/stb onto the APB outputs, and go to SETUP next cycle; otherwise remain in IDLE.
REQ-019 Arbitration SHALL be round-robin: single request is granted directly; if both are set, the requester not granted last wins; the last-grant register resets to 1 so m0 wins the first tie.
REQ-020 SETUP: psel=1, penable=0, one cycle, then ACCESS unconditionally.
REQ-021 ACCESS: psel=1, penable=1; if pready=1, register prdata and perr for the owner and go to RESP.
REQ-022 A watchdog counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; on reaching TIMEOUT-1 without pready, it SHALL complete with err=1 and rdata=0, then go to RESP.
REQ-023 RESP: psel=0, penable=0; the owner's done=1 for exactly this cycle; requests are ignored; the last-grant register updates to the owner; next state is IDLE.
REQ-024 Requesters SHALL deassert req or present a new transfer in the RESP cycle; a request held through RESP starts a new transfer (minimum 4 cycles per transfer).
REQ-025 pstb SHALL equal the granted stb for writes and 4'b0000 for reads.
REQ-026 paddr/pdata/pwrite/pstb SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-027 The non-owner's done/err SHALL stay 0; each mX_rdata/mX_err SHALL hold its last value until the next completion for that requester.
REQ-028 Requests arriving outside IDLE SHALL wait, with no loss, until the next IDLE.

Reset
REQ-029 Reset assertion SHALL immediately force IDLE, regardless of the current state: psel=0, penable=0, paddr=0, pdata=0, pwrite=0, pstb=0, m0/m1_done=0, m0/m1_rdata=0, m0/m1_err=0, watchdog=0, last-grant=1.
REQ-030 A transfer interrupted by reset SHALL produce no done pulse; the first post-reset grant follows REQ-018/019.

Structure
REQ-031 The FSM state enum and the default TIMEOUT constant SHALL be in the shared package apb_pkg.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 m0 read addr 0x80000010, pready=1 first ACCESS, prdata=0xDEADBEEF -> SETUP cycle 1, ACCESS cycle 2, m0_done cycle 3 with m0_rdata=0xDEADBEEF, m0_err=0.
REQ-034 Both request continuously from reset -> grants alternate m0, m1, m0, m1; each done pulse occurs once per grant.
REQ-035 m1 write addr 0x10000000, stb=0x3, pready held 0 -> err completion after TIMEOUT ACCESS cycles, m1_done with m1_err=1, m1_rdata=0.
REQ-036 m1 read with perr=1 and pready=1 -> m1_err=1; then m0 write -> pstb equals m0_stb, and pstb=0 on the earlier read.
REQ-037 presetn low during ACCESS -> psel/penable drop asynchronously, no done; after release, the pending m0 request is granted first.
